// File: rtl/camara_if.sv
// camara_if: pin bundle between the camara controller and an OV7670-class camera.
//   Vsync, Href, Pclk, Imagen : driven by the camera (asynchronous to the system clock)
//   Xclk, Reset, PWDN         : driven by the controller
// modport master : the controller side (camara)
// modport slave  : the camera side (camera model / testbench)
`timescale 1ns/1ps
interface camara_if;
  logic       Vsync;
  logic       Href;
  logic       Pclk;
  logic [7:0] Imagen;
  logic       Xclk;
  logic       Reset;
  logic       PWDN;

  modport master (
    input  Vsync, Href, Pclk, Imagen,
    output Xclk, Reset, PWDN
  );

  modport slave (
    output Vsync, Href, Pclk, Imagen,
    input  Xclk, Reset, PWDN
  );
endinterface

// File: rtl/camara.sv
// camara: control and capture front end for an OV7670-class parallel camera.
// Generates the camera master clock, sequences power-down and reset pins,
// and once running captures 16-bit pixels from the 8-bit pixel bus.
// Ports:
//   clk : system clock, all logic on its rising edge
//   rst : synchronous active-low reset
//   cam : camara_if.master (Vsync/Href/Pclk/Imagen in, Xclk/Reset/PWDN out)
// Internal observables (read hierarchically): state, frame_cnt, line_cnt,
// pixel_cnt, pixel_data, pixel_valid. These registers carry those exact
// names; their next values are the matching *_d signals.
`timescale 1ns/1ps
module camara #(
  parameter int XCLK_DIV      = 4,
  parameter int PWDN_CYCLES   = 16,
  parameter int CAMRST_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst,
  camara_if.master cam
);

  localparam int XHALF   = XCLK_DIV / 2;
  localparam int XCW     = (XHALF > 1) ? $clog2(XHALF) : 1;
  localparam int SEQ_MAX = (PWDN_CYCLES > CAMRST_CYCLES) ? PWDN_CYCLES : CAMRST_CYCLES;
  localparam int SCW     = $clog2(SEQ_MAX + 1);

  localparam logic [XCW-1:0] XCNT_LAST   = XCW'(XHALF - 1);
  localparam logic [SCW-1:0] PWDN_LAST   = SCW'(PWDN_CYCLES - 1);
  localparam logic [SCW-1:0] CAMRST_LAST = SCW'(CAMRST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PWDN   = 2'd0,
    S_CAMRST = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  // Clock generation and sequencing
  logic [XCW-1:0] xclk_cnt_q, xclk_cnt_d;
  logic           xclk_q, xclk_d;
  state_e         state, state_d;
  logic [SCW-1:0] seq_cnt_q, seq_cnt_d;
  logic           pwdn_q, pwdn_d;
  logic           cam_rst_q, cam_rst_d;

  // Synchronizers: bit 0/1 form the 2-flop synchronizer, bit 2 is the
  // previous synchronized value used for edge detection.
  logic [2:0]      vsync_sync_q, vsync_sync_d;
  logic [2:0]      href_sync_q, href_sync_d;
  logic [2:0]      pclk_sync_q, pclk_sync_d;
  logic [1:0][7:0] imagen_pipe_q, imagen_pipe_d;

  // Capture registers
  logic [7:0]  frame_cnt, frame_cnt_d;
  logic [8:0]  line_cnt, line_cnt_d;
  logic [9:0]  pixel_cnt, pixel_cnt_d;
  logic [15:0] pixel_data, pixel_data_d;
  logic        pixel_valid, pixel_valid_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        byte_sel_q, byte_sel_d;

  logic vsync_rise_s;
  logic href_fall_s;
  logic pclk_rise_s;
  logic href_s;
  logic [7:0] imagen_s;

  assign href_s       = href_sync_q[1];
  assign imagen_s     = imagen_pipe_q[1];
  assign vsync_rise_s = vsync_sync_q[1] & ~vsync_sync_q[2];
  assign pclk_rise_s  = pclk_sync_q[1] & ~pclk_sync_q[2];
  assign href_fall_s  = ~href_sync_q[1] & href_sync_q[2];

  assign cam.Xclk  = xclk_q;
  assign cam.Reset = cam_rst_q;
  assign cam.PWDN  = pwdn_q;

  // Xclk divider: toggle every XCLK_DIV/2 cycles for a 50% duty clock.
  always_comb begin
    xclk_cnt_d = xclk_cnt_q + XCW'(1);
    xclk_d     = xclk_q;
    if (xclk_cnt_q == XCNT_LAST) begin
      xclk_cnt_d = '0;
      xclk_d     = ~xclk_q;
    end else begin
      xclk_d     = xclk_q;
    end
  end

  // Power-up sequencer; pin values follow the state being entered so they
  // change on the same edge as the state.
  always_comb begin
    state_d   = state;
    seq_cnt_d = seq_cnt_q + SCW'(1);
    case (state)
      S_PWDN: begin
        if (seq_cnt_q == PWDN_LAST) begin
          state_d   = S_CAMRST;
          seq_cnt_d = '0;
        end else begin
          state_d   = S_PWDN;
        end
      end
      S_CAMRST: begin
        if (seq_cnt_q == CAMRST_LAST) begin
          state_d   = S_RUN;
          seq_cnt_d = '0;
        end else begin
          state_d   = S_CAMRST;
        end
      end
      S_RUN: begin
        state_d   = S_RUN;
        seq_cnt_d = seq_cnt_q;
      end
      default: begin
        state_d   = S_PWDN;
        seq_cnt_d = '0;
      end
    endcase
    pwdn_d    = (state_d == S_PWDN);
    cam_rst_d = (state_d == S_RUN);
  end

  // Input synchronizers; Imagen is delayed by the same two stages as Pclk.
  always_comb begin
    vsync_sync_d  = {vsync_sync_q[1:0], cam.Vsync};
    href_sync_d   = {href_sync_q[1:0], cam.Href};
    pclk_sync_d   = {pclk_sync_q[1:0], cam.Pclk};
    imagen_pipe_d = {imagen_pipe_q[0], cam.Imagen};
  end

  // Capture: frame start beats line end; line end beats pixel bytes.
  always_comb begin
    frame_cnt_d   = frame_cnt;
    line_cnt_d    = line_cnt;
    pixel_cnt_d   = pixel_cnt;
    pixel_data_d  = pixel_data;
    pixel_valid_d = 1'b0;
    hi_byte_d     = hi_byte_q;
    byte_sel_d    = byte_sel_q;
    if (state != S_RUN) begin
      frame_cnt_d  = 8'd0;
      line_cnt_d   = 9'd0;
      pixel_cnt_d  = 10'd0;
      pixel_data_d = 16'd0;
      hi_byte_d    = 8'd0;
      byte_sel_d   = 1'b0;
    end else if (vsync_rise_s) begin
      frame_cnt_d = frame_cnt + 8'd1;
      line_cnt_d  = 9'd0;
      pixel_cnt_d = 10'd0;
      byte_sel_d  = 1'b0;
    end else if (href_fall_s) begin
      // Lines with no complete pixel do not count; an odd byte is dropped.
      if (pixel_cnt != 10'd0) begin
        line_cnt_d = line_cnt + 9'd1;
      end else begin
        line_cnt_d = line_cnt;
      end
      pixel_cnt_d = 10'd0;
      byte_sel_d  = 1'b0;
    end else if (pclk_rise_s && href_s) begin
      if (!byte_sel_q) begin
        hi_byte_d  = imagen_s;
        byte_sel_d = 1'b1;
      end else begin
        pixel_data_d  = {hi_byte_q, imagen_s};
        pixel_valid_d = 1'b1;
        pixel_cnt_d   = pixel_cnt + 10'd1;
        byte_sel_d    = 1'b0;
      end
    end else begin
      byte_sel_d = byte_sel_q;
    end
  end

  // State register for all logic, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      xclk_cnt_q    <= '0;
      xclk_q        <= 1'b0;
      state         <= S_PWDN;
      seq_cnt_q     <= '0;
      pwdn_q        <= 1'b1;
      cam_rst_q     <= 1'b0;
      vsync_sync_q  <= 3'd0;
      href_sync_q   <= 3'd0;
      pclk_sync_q   <= 3'd0;
      imagen_pipe_q <= '0;
      frame_cnt     <= 8'd0;
      line_cnt      <= 9'd0;
      pixel_cnt     <= 10'd0;
      pixel_data    <= 16'd0;
      pixel_valid   <= 1'b0;
      hi_byte_q     <= 8'd0;
      byte_sel_q    <= 1'b0;
    end else begin
      xclk_cnt_q    <= xclk_cnt_d;
      xclk_q        <= xclk_d;
      state         <= state_d;
      seq_cnt_q     <= seq_cnt_d;
      pwdn_q        <= pwdn_d;
      cam_rst_q     <= cam_rst_d;
      vsync_sync_q  <= vsync_sync_d;
      href_sync_q   <= href_sync_d;
      pclk_sync_q   <= pclk_sync_d;
      imagen_pipe_q <= imagen_pipe_d;
      frame_cnt     <= frame_cnt_d;
      line_cnt      <= line_cnt_d;
      pixel_cnt     <= pixel_cnt_d;
      pixel_data    <= pixel_data_d;
      pixel_valid   <= pixel_valid_d;
      hi_byte_q     <= hi_byte_d;
      byte_sel_q    <= byte_sel_d;
    end
  end

endmodule

// File: tb/tb_camara.sv
// tb_camara: directed self-checking bench for camara.
// Drives the camera pins through a camara_if instance and checks the pin
// sequence plus the internal capture registers with hand-computed values.
`timescale 1ns/1ps
module tb_camara;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  logic [15:0] pix_q[$];

  camara_if cam ();

  camara dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Record every pixel_valid pulse and the pixel presented with it.
  always @(negedge clk) begin
    if (dut.pixel_valid === 1'b1) begin
      valid_cnt++;
      pix_q.push_back(dut.pixel_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One Pclk period of 80 ns with the byte set up before the rising edge.
  task automatic send_byte(input logic [7:0] b);
    cam.Imagen = b;
    wait_clk(4);
    cam.Pclk = 1'b1;
    wait_clk(4);
    cam.Pclk = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int f, input int l, input int p);
    check({tag, "_frame"}, {24'd0, dut.frame_cnt}, f);
    check({tag, "_line"},  {23'd0, dut.line_cnt}, l);
    check({tag, "_pixel"}, {22'd0, dut.pixel_cnt}, p);
  endtask

  // Called right after rst is released at a negedge; k counts edges since release.
  task automatic check_sequence();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("seq%0d_PWDN", k),  {31'd0, cam.PWDN},  (k < 16) ? 1 : 0);
      check($sformatf("seq%0d_Reset", k), {31'd0, cam.Reset}, (k >= 32) ? 1 : 0);
      check($sformatf("seq%0d_Xclk", k),  {31'd0, cam.Xclk},  (k / 2) % 2);
      check_counts($sformatf("seq%0d", k), 0, 0, 0);
    end
  endtask

  // Camera activity while the sequencer is still in power-down / camera reset.
  task automatic pre_run_activity();
    wait_clk(2);
    cam.Vsync = 1'b1;
    wait_clk(2);
    cam.Vsync = 1'b0;
    cam.Href  = 1'b1;
    send_byte(8'h5A);
    send_byte(8'hA5);
    cam.Href  = 1'b0;
  endtask

  initial begin
    cam.Vsync  = 1'b0;
    cam.Href   = 1'b0;
    cam.Pclk   = 1'b0;
    cam.Imagen = 8'h00;
    rst        = 1'b0;

    // Reset held for 500 ns
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        check("rst_Xclk",  {31'd0, cam.Xclk},  32'd0);
        check("rst_Reset", {31'd0, cam.Reset}, 32'd0);
        check("rst_PWDN",  {31'd0, cam.PWDN},  32'd1);
        check_counts("rst", 0, 0, 0);
      end
    end

    // Release: 16 + 16 sequence with pre-run pin activity that must be ignored
    rst = 1'b1;
    fork
      check_sequence();
      pre_run_activity();
    join
    check("run_state", {30'd0, dut.state}, 32'd2);
    check("prerun_valids", valid_cnt, 0);

    // Frame start
    cam.Vsync = 1'b1;
    wait_clk(4);
    cam.Vsync = 1'b0;
    wait_clk(4);
    check_counts("vsync1", 1, 0, 0);

    // Line of 4 bytes -> 2 pixels
    cam.Href = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    check("line1_pixcnt", {22'd0, dut.pixel_cnt}, 32'd2);
    cam.Href = 1'b0;
    wait_clk(6);
    check_counts("line1_end", 1, 1, 0);
    check("line1_valids", valid_cnt, 2);
    check("line1_pix0", (pix_q.size() > 0) ? {16'd0, pix_q[0]} : 32'hFFFF_FFFF, 32'h0000_A1B2);
    check("line1_pix1", (pix_q.size() > 1) ? {16'd0, pix_q[1]} : 32'hFFFF_FFFF, 32'h0000_C3D4);

    // Odd line: 3 bytes -> 1 pixel, last byte dropped
    cam.Href = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cam.Href = 1'b0;
    wait_clk(6);
    check_counts("odd_end", 1, 2, 0);
    check("odd_valids", valid_cnt, 3);
    check("odd_pix", (pix_q.size() > 2) ? {16'd0, pix_q[2]} : 32'hFFFF_FFFF, 32'h0000_1122);

    // Next line starts on a fresh high byte
    cam.Href = 1'b1;
    send_byte(8'h44);
    send_byte(8'h55);
    cam.Href = 1'b0;
    wait_clk(6);
    check_counts("after_odd", 1, 3, 0);
    check("after_odd_pix", (pix_q.size() > 3) ? {16'd0, pix_q[3]} : 32'hFFFF_FFFF, 32'h0000_4455);

    // Empty line: no Pclk rises
    cam.Href = 1'b1;
    wait_clk(8);
    cam.Href = 1'b0;
    wait_clk(6);
    check_counts("empty_line", 1, 3, 0);

    // Pclk edges with Href low are ignored
    send_byte(8'h99);
    send_byte(8'h77);
    wait_clk(4);
    check_counts("href_low", 1, 3, 0);
    check("href_low_valids", valid_cnt, 4);

    // Second frame start clears the line count
    cam.Vsync = 1'b1;
    wait_clk(4);
    cam.Vsync = 1'b0;
    wait_clk(4);
    check_counts("vsync2", 2, 0, 0);

    // Reset in the middle of a line
    cam.Href = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    wait_clk(4);
    check("mid_pixcnt", {22'd0, dut.pixel_cnt}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_Xclk",  {31'd0, cam.Xclk},  32'd0);
    check("mid_Reset", {31'd0, cam.Reset}, 32'd0);
    check("mid_PWDN",  {31'd0, cam.PWDN},  32'd1);
    check("mid_state", {30'd0, dut.state}, 32'd0);
    check_counts("mid_rst", 0, 0, 0);
    cam.Href   = 1'b0;
    cam.Imagen = 8'h00;
    wait_clk(5);
    rst = 1'b1;
    check_sequence();
    check("rerun_state", {30'd0, dut.state}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
